// File: rtl/bsg_mem_1rw_sync_client_pkg.sv
// Shared helpers for the bsg_mem_1rw_sync_client slice.
// Width functions stay at least one bit wide so depth-1 configurations still elaborate.
package bsg_mem_1rw_sync_client_pkg;

  // Bits needed to index n entries (0..n-1).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_client_rbuf.sv
// In-order 1r1w flop buffer holding captured read data until the consumer yumis it.
// Pointers wrap modulo els_p, so the depth need not be a power of two.
module bsg_mem_1rw_sync_client_rbuf
  import bsg_mem_1rw_sync_client_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 2,
  localparam int ptr_width_lp = idx_width(els_p),
  localparam int cnt_width_lp = count_width(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enq_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    deq_i,
  output logic [width_p-1:0]      data_o,
  output logic [cnt_width_lp-1:0] count_o
);

  logic [width_p-1:0]      r_mem [els_p];
  logic [ptr_width_lp-1:0] r_wr_ptr;
  logic [ptr_width_lp-1:0] r_rd_ptr;
  logic [cnt_width_lp-1:0] r_count;
  logic [cnt_width_lp-1:0] w_count_nxt;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_count_nxt = r_count;  // NOTE: default assigned first so no latch is inferred
    unique case ({enq_i, deq_i})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: ;
    endcase
  end

  // NOTE: storage has no reset; r_count alone decides which entries are visible
  always_ff @(posedge clk_i) begin
    if (enq_i) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (enq_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (deq_i) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  a_enq_not_full: assert property (@(posedge clk_i) disable iff (reset_i)
    enq_i |-> (r_count != cnt_width_lp'(els_p)));
  a_deq_not_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_i |-> (r_count != '0));

endmodule

// File: rtl/bsg_mem_1rw_sync_client.sv
// Adapter driving a bsg_mem_1rw_sync port from a valid/ready request stream and
// returning read data on a valid/yumi stream; credits guarantee every read has a slot.
module bsg_mem_1rw_sync_client
  import bsg_mem_1rw_sync_client_pkg::*;
#(
  parameter int width_p    = 32,
  parameter int els_p      = 16,
  parameter int rbuf_els_p = 2,
  localparam int addr_width_lp = idx_width(els_p),
  localparam int cred_width_lp = count_width(rbuf_els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i
);

  logic                     rd_pending_r;
  logic [cred_width_lp-1:0] credits_r;
  logic [cred_width_lp-1:0] w_credits_nxt;
  logic [cred_width_lp-1:0] w_count;
  logic                     w_rd_accept;

  // Writes also need a credit so ready_o never depends on w_i.
  assign ready_o     = (credits_r != '0) & ~reset_i;
  assign mem_v_o     = v_i & ready_o;
  assign mem_w_o     = w_i;
  assign mem_addr_o  = addr_i;
  assign mem_data_o  = data_i;
  assign w_rd_accept = mem_v_o & ~w_i;
  assign v_o         = (w_count != '0);

  always_comb begin
    w_credits_nxt = credits_r;
    unique case ({w_rd_accept, yumi_i})
      2'b10:   w_credits_nxt = credits_r - 1'b1;
      2'b01:   w_credits_nxt = credits_r + 1'b1;
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pending_r <= 1'b0;
      credits_r    <= cred_width_lp'(rbuf_els_p);
    end else begin
      rd_pending_r <= w_rd_accept;
      credits_r    <= w_credits_nxt;
    end
  end

  // The RAM's read data is valid exactly one cycle after issue and is captured unconditionally.
  bsg_mem_1rw_sync_client_rbuf #(
    .width_p (width_p),
    .els_p   (rbuf_els_p)
  ) rbuf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (rd_pending_r),
    .data_i  (mem_data_i),
    .deq_i   (yumi_i),
    .data_o  (data_o),
    .count_o (w_count)
  );

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o);
  a_w_known: assert property (@(posedge clk_i) disable iff (reset_i)
    v_i |-> !$isunknown(w_i));
  a_credit_sum: assert property (@(posedge clk_i) disable iff (reset_i)
    (32'(credits_r) + 32'(w_count) + 32'(rd_pending_r)) == 32'(rbuf_els_p));

endmodule

// File: tb/tb_bsg_mem_1rw_sync_client.sv
// Self-checking bench: client plus a behavioural 1rw sync RAM, checked against a
// queue-based model of outstanding reads and a shadow copy of the RAM.
module tb_bsg_mem_1rw_sync_client;

  localparam int W    = 32;
  localparam int ELS  = 16;
  localparam int AW   = 4;
  // Accept-to-credit-return is three cycles, so back-to-back reads need three slots.
  localparam int RBUF = 3;

  logic          clk_i = 1'b0;
  logic          reset_i, v_i, w_i, yumi_i;
  logic [AW-1:0] addr_i;
  logic [W-1:0]  data_i;
  logic          ready_o, v_o, mem_v_o, mem_w_o;
  logic [W-1:0]  data_o, mem_data_o, mem_data_i;
  logic [AW-1:0] mem_addr_o;

  always #5 clk_i = ~clk_i;

  bsg_mem_1rw_sync_client #(
    .width_p    (W),
    .els_p      (ELS),
    .rbuf_els_p (RBUF)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .w_i        (w_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .mem_v_o    (mem_v_o),
    .mem_w_o    (mem_w_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  // Behavioural bsg_mem_1rw_sync: read data appears the cycle after issue.
  logic [W-1:0] ram [ELS];
  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) ram[mem_addr_o] <= mem_data_o;
      else         mem_data_i      <= ram[mem_addr_o];
    end
  end

  // Reference model: every accepted read waits in exp_q until consumed; it becomes
  // visible two cycles after acceptance, and the queue length is what holds credits.
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } resp_t;

  resp_t        exp_q[$];
  logic [W-1:0] shadow [ELS];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  function automatic bit exp_ready();
    return !reset_i && (exp_q.size() < RBUF);
  endfunction

  function automatic bit exp_v();
    return (exp_q.size() > 0) && (exp_q[0].due <= cyc);
  endfunction

  function automatic logic [W-1:0] exp_data();
    return (exp_q.size() > 0) ? exp_q[0].data : '0;
  endfunction

  task automatic drive(input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input bit y);
    v_i = v; w_i = w; addr_i = a; data_i = d; yumi_i = y;
    #1;
  endtask

  task automatic advance();
    bit acc;
    acc = v_i && exp_ready();
    if (reset_i) begin
      exp_q.delete();
    end else begin
      if (yumi_i && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        if (w_i) shadow[addr_i] = data_i;
        else     exp_q.push_back('{data: shadow[addr_i], due: cyc + 2});
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'd0, '0, 1'b0);
      n_checks++; if (mem_v_o !== 1'b0) $display("FAIL reset_mem_v: got %b expected 0", mem_v_o); else n_pass++;
      n_checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_o); else n_pass++;
      n_checks++; if (v_o !== 1'b0) $display("FAIL reset_v_o: got %b expected 0", v_o); else n_pass++;
      advance();
    end
    reset_i = 1'b0;
    drive(1'b0, 1'b0, 4'd0, '0, 1'b0);
    n_checks++; if (ready_o !== 1'b1) $display("FAIL release_ready: got %b expected 1", ready_o); else n_pass++;
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0);
    n_checks++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1) $display("FAIL wr_issue: got v=%b w=%b expected 1 1", mem_v_o, mem_w_o); else n_pass++;
    n_checks++; if (mem_addr_o !== 4'd5 || mem_data_o !== 32'hDEAD_BEEF) $display("FAIL wr_pass: got %h/%h expected 5/deadbeef", mem_addr_o, mem_data_o); else n_pass++;
    advance();
    drive(1'b1, 1'b0, 4'd5, '0, 1'b0);
    n_checks++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b0) $display("FAIL rd_issue: got v=%b w=%b expected 1 0", mem_v_o, mem_w_o); else n_pass++;
    advance();
    drive(1'b0, 1'b0, 4'd0, '0, 1'b0);
    n_checks++; if (v_o !== 1'b0) $display("FAIL rd_early: got v_o=%b expected 0 one cycle after accept", v_o); else n_pass++;
    advance();
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
    n_checks++; if (v_o !== 1'b1) $display("FAIL rd_latency: got v_o=%b expected 1 two cycles after accept", v_o); else n_pass++;
    n_checks++; if (data_o !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h expected deadbeef", data_o); else n_pass++;
    advance();
    drive(1'b0, 1'b0, 4'd0, '0, 1'b0);
    n_checks++; if (v_o !== 1'b0) $display("FAIL rd_drained: got v_o=%b expected 0", v_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got = 0;
    for (int a = 0; a < ELS; a++) begin
      drive(1'b1, 1'b1, AW'(a), W'(a * 3), 1'b0);
      n_checks++; if (ready_o !== 1'b1) $display("FAIL b2b_wr_ready: addr %0d got %b expected 1", a, ready_o); else n_pass++;
      advance();
    end
    for (int i = 0; i < ELS + 2; i++) begin
      bit y;
      y = exp_v();
      drive(i < ELS, 1'b0, AW'(i), '0, y);
      if (i < ELS) begin
        n_checks++; if (ready_o !== 1'b1) $display("FAIL b2b_rd_ready: cycle %0d got %b expected 1", i, ready_o); else n_pass++;
      end
      n_checks++; if (v_o !== y) $display("FAIL b2b_v_o: cycle %0d got %b expected %b", i, v_o, y); else n_pass++;
      if (y) begin
        n_checks++; if (data_o !== W'(got * 3)) $display("FAIL b2b_data: resp %0d got %h expected %h", got, data_o, W'(got * 3)); else n_pass++;
        got++;
      end
      advance();
    end
    n_checks++; if (got != ELS) $display("FAIL b2b_count: got %0d responses expected %0d", got, ELS); else n_pass++;
  endtask

  task automatic test_full_stall();
    int acc = 0;
    for (int i = 0; i < RBUF + 3; i++) begin
      drive(1'b1, 1'b0, AW'($urandom_range(0, ELS - 1)), '0, 1'b0);
      n_checks++; if (ready_o !== exp_ready()) $display("FAIL full_ready: cycle %0d got %b expected %b", i, ready_o, exp_ready()); else n_pass++;
      if (ready_o === 1'b1) acc++;
      advance();
    end
    n_checks++; if (acc != RBUF) $display("FAIL full_accepts: got %0d expected %0d", acc, RBUF); else n_pass++;
    drive(1'b1, 1'b1, 4'd3, '1, 1'b0);
    n_checks++; if (ready_o !== 1'b0 || mem_v_o !== 1'b0) $display("FAIL full_write_stall: got ready=%b mem_v=%b expected 0 0", ready_o, mem_v_o); else n_pass++;
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
      n_checks++; if (v_o !== 1'b1 || data_o !== exp_data()) $display("FAIL full_pop: got v=%b %h expected 1 %h", v_o, data_o, exp_data()); else n_pass++;
      advance();
      drive(1'b1, 1'b0, AW'(k + 9), '0, 1'b0);
      n_checks++; if (ready_o !== 1'b1) $display("FAIL full_reopen: pulse %0d got %b expected 1", k, ready_o); else n_pass++;
      advance();
      drive(1'b1, 1'b0, AW'(k + 9), '0, 1'b0);
      n_checks++; if (ready_o !== 1'b0) $display("FAIL full_one_slot: pulse %0d got %b expected 0", k, ready_o); else n_pass++;
      advance();
    end
    for (int i = 0; i < 2 * RBUF + 2; i++) begin
      bit y;
      y = exp_v();
      drive(1'b0, 1'b0, 4'd0, '0, y);
      n_checks++; if (v_o !== y || (y && data_o !== exp_data())) $display("FAIL full_drain: got v=%b %h expected %b %h", v_o, data_o, y, exp_data()); else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 4'd7, '0, 1'b0);
    n_checks++; if (ready_o !== 1'b1) $display("FAIL mid_accept: got %b expected 1", ready_o); else n_pass++;
    advance();
    reset_i = 1'b1;
    drive(1'b1, 1'b0, 4'd7, '0, 1'b0);
    n_checks++; if (mem_v_o !== 1'b0 || ready_o !== 1'b0) $display("FAIL mid_reset_block: got mem_v=%b ready=%b expected 0 0", mem_v_o, ready_o); else n_pass++;
    advance();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'd0, '0, 1'b0);
      n_checks++; if (v_o !== 1'b0) $display("FAIL mid_no_resp: cycle %0d got v_o=%b expected 0", i, v_o); else n_pass++;
      advance();
    end
    n_checks++; if (int'(dut.credits_r) != RBUF) $display("FAIL mid_credits: got %0d expected %0d", dut.credits_r, RBUF); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 10000; i++) begin
      bit v, w, y, er, ev;
      reset_i = ($urandom_range(0, 999) == 0);
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      y  = exp_v() && $urandom_range(0, 1) == 1;
      drive(v, w, AW'($urandom_range(0, ELS - 1)), W'($urandom), y);
      er = exp_ready();
      ev = exp_v();
      n_checks++; if (ready_o !== er) begin $display("FAIL rnd_ready: cycle %0d got %b expected %b", i, ready_o, er); errs++; end else n_pass++;
      n_checks++; if (mem_v_o !== (v && er)) begin $display("FAIL rnd_mem_v: cycle %0d got %b expected %b", i, mem_v_o, v && er); errs++; end else n_pass++;
      n_checks++; if (v_o !== ev) begin $display("FAIL rnd_v_o: cycle %0d got %b expected %b", i, v_o, ev); errs++; end else n_pass++;
      if (ev) begin
        n_checks++; if (data_o !== exp_data()) begin $display("FAIL rnd_data: cycle %0d got %h expected %h", i, data_o, exp_data()); errs++; end else n_pass++;
      end
      advance();
      if (errs > 20) break;
    end
    reset_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; v_i = 1'b1; w_i = 1'b0; addr_i = '0; data_i = '0; yumi_i = 1'b0;
    @(posedge clk_i);
    #1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
